pll_lock_supervisor: RTL and testbench
======================================

# pll_lock_supervisor

Lock supervisor and reset sequencer for the iCE40 PLL that turns the 14.4 MHz reference into the 57.6 MHz system clock. It runs on the reference clock, so it keeps running while the PLL output is absent or unstable. It drives the PLL's active-low reset, qualifies the PLL's asynchronous LOCK output, retries lock acquisition on timeout, and holds the system reset until lock has been stable for a programmed time. SYS_RESET is re-synchronised into the PLL output domain downstream; this block does not do that.

## Interface
- HOLD_CYCLES, 16: PLL_RESETB low duration per attempt, in REFERENCECLK cycles; ≥2.
- LOCK_TIMEOUT, 14400: max cycles to wait for lock per attempt (1 ms); ≥2.
- STABLE_CYCLES, 1440: consecutive locked cycles required before release (100 µs); ≥2.
- MAX_RETRIES, 7: timeouts tolerated before FAULT; 1..7.
- REFERENCECLK  in  1  reference clock; the only clock.
- RESET  in  1  asynchronous, active-high reset.
- LOCK  in  1  PLL lock, asynchronous to REFERENCECLK.
- FORCE_RELOCK  in  1  synchronous single-cycle request to restart the sequence.
- PLL_RESETB  out  1  active-low PLL reset.
- SYS_RESET  out  1  active-high system reset; released only in RUN.
- READY  out  1  high only in RUN.
- FAULT  out  1  high only in FAULT.
- RETRY_COUNT  out  3  timeouts in the current acquisition.
- LOSS_COUNT  out  8  lock losses while in RUN; saturates at 255.

## Operation
- LOCK passes through a 2-flop synchronizer (reset 0). The FSM uses lock_s, the synchronizer output.
- There is one shared cycle counter. Its width is clog2 of the largest of the three cycle parameters. It clears on every state change.
- States:
  - HOLD: PLL_RESETB=0. When counter==HOLD_CYCLES-1, go to WAIT_LOCK.
  - WAIT_LOCK: PLL_RESETB=1. If lock_s, go to STABLE.
    - Otherwise, if counter==LOCK_TIMEOUT-1 and RETRY_COUNT==MAX_RETRIES, go to FAULT.
    - Otherwise, if counter==LOCK_TIMEOUT-1, go to HOLD and increment RETRY_COUNT.
  - STABLE: PLL_RESETB=1. If !lock_s, go to WAIT_LOCK; the timeout restarts and RETRY_COUNT is unchanged. If counter==STABLE_CYCLES-1, go to RUN.
  - RUN: PLL_RESETB=1, SYS_RESET=0, READY=1. RETRY_COUNT clears on entry. If !lock_s, increment LOSS_COUNT (saturating) and go to HOLD.
  - FAULT: PLL_RESETB=0, SYS_RESET=1, FAULT=1. The state is held until RESET or FORCE_RELOCK.
- FORCE_RELOCK has priority in every state. It goes to HOLD and clears RETRY_COUNT and the counter. LOSS_COUNT is preserved. If a lock loss in RUN coincides with FORCE_RELOCK, LOSS_COUNT still increments.
- SYS_RESET=1 and READY=0 in every state except RUN.

## Timing
- All outputs are registered and change on the same edge as the state transition.
- Reset values while RESET is high or on deassertion:
  - state HOLD, counter 0, synchronizer 0;
  - PLL_RESETB=0, SYS_RESET=1, READY=0, FAULT=0;
  - RETRY_COUNT=0, LOSS_COUNT=0.
- RESET asserting mid-operation forces the reset values immediately, without a clock edge.
- PLL_RESETB stays low for exactly HOLD_CYCLES cycles per attempt.
- LOCK-to-FSM latency is 2 edges; the FSM reacts on the 3rd edge. RUN is entered STABLE_CYCLES edges after STABLE entry. Net: READY rises STABLE_CYCLES+2 edges after the first edge that samples LOCK high.
- Lock loss in RUN: READY falls and SYS_RESET rises on the 3rd edge after LOCK falls.
- Timeout: WAIT_LOCK lasts exactly LOCK_TIMEOUT cycles without lock.
- Total attempts before FAULT = MAX_RETRIES+1.

## Test plan
Parameters for all cases: HOLD_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2.
- Nominal acquisition:
  - Stimulus: release RESET; drive LOCK high 5 cycles after PLL_RESETB rises.
  - Required: PLL_RESETB low exactly 4 cycles; READY=1 and SYS_RESET=0 10 edges after LOCK is first sampled; RETRY_COUNT=0.
- Lock never arrives:
  - Stimulus: LOCK held at 0.
  - Required: three WAIT_LOCK windows of 20 cycles, each preceded by a 4-cycle PLL_RESETB low pulse; RETRY_COUNT steps 1, 2; FAULT=1 after the 3rd timeout with RETRY_COUNT=2, PLL_RESETB=0, SYS_RESET=1.
- Glitch during STABLE:
  - Stimulus: LOCK drops for 3 cycles after 5 STABLE cycles.
  - Required: return to WAIT_LOCK; READY stays 0; READY rises only after 8 fresh consecutive locked cycles; no PLL_RESETB pulse.
- Lock loss in RUN:
  - Stimulus: drop LOCK while READY=1.
  - Required: READY falls 3 edges later; LOSS_COUNT=1; PLL_RESETB low 4 cycles; re-acquire when LOCK returns.
  - Also: force 256 losses and check LOSS_COUNT=255.
- FORCE_RELOCK:
  - From FAULT: FAULT=0, RETRY_COUNT=0 next edge, then a 4-cycle PLL_RESETB pulse.
  - In RUN, coincident with a LOCK drop: LOSS_COUNT increments and the sequence proceeds to HOLD.
- Asynchronous reset:
  - Stimulus: assert RESET between clock edges while in RUN.
  - Required: PLL_RESETB=0, SYS_RESET=1, READY=0, LOSS_COUNT=0 before the next edge.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer and lock qualifier running on the reference clock.
// Latency: LOCK reaches the FSM after a 2-flop synchronizer; all outputs are registered.
// Backpressure: none; FORCE_RELOCK restarts the sequence from any state.
module pll_lock_supervisor #(
    parameter int HOLD_CYCLES   = 16,
    parameter int LOCK_TIMEOUT  = 14400,
    parameter int STABLE_CYCLES = 1440,
    parameter int MAX_RETRIES   = 7
) (
    input  logic       REFERENCECLK,
    input  logic       RESET,
    input  logic       LOCK,
    input  logic       FORCE_RELOCK,
    output logic       PLL_RESETB,
    output logic       SYS_RESET,
    output logic       READY,
    output logic       FAULT,
    output logic [2:0] RETRY_COUNT,
    output logic [7:0] LOSS_COUNT
);

    localparam int MAX_AB  = (HOLD_CYCLES > LOCK_TIMEOUT) ? HOLD_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CYC = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int CW      = $clog2(MAX_CYC);

    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [2:0]    RETRY_MAX   = 3'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_HOLD,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAULT
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic            lock_m;
    logic            lock_s;
    logic [2:0]      retry_nxt;
    logic [7:0]      loss_nxt;
    logic            cnt_clr;
    logic            resetb_nxt;
    logic            sys_reset_nxt;
    logic            ready_nxt;
    logic            fault_nxt;

    always_ff @(posedge REFERENCECLK or posedge RESET) begin
        if (RESET) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= LOCK;
            lock_s <= lock_m;
        end
    end

    // State, shared counter and registered outputs all update on the same edge.
    always_ff @(posedge REFERENCECLK or posedge RESET) begin
        if (RESET) begin
            state       <= S_HOLD;
            cnt         <= '0;
            PLL_RESETB  <= 1'b0;
            SYS_RESET   <= 1'b1;
            READY       <= 1'b0;
            FAULT       <= 1'b0;
            RETRY_COUNT <= 3'd0;
            LOSS_COUNT  <= 8'd0;
        end else begin
            state       <= state_nxt;
            PLL_RESETB  <= resetb_nxt;
            SYS_RESET   <= sys_reset_nxt;
            READY       <= ready_nxt;
            FAULT       <= fault_nxt;
            RETRY_COUNT <= retry_nxt;
            LOSS_COUNT  <= loss_nxt;
            if (cnt_clr) begin
                cnt <= '0;
            end else if (state inside {S_HOLD, S_WAIT_LOCK, S_STABLE}) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        retry_nxt = RETRY_COUNT;
        case (state)
            S_HOLD: begin
                if (cnt == HOLD_LAST) state_nxt = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (lock_s) begin
                    state_nxt = S_STABLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    if (RETRY_COUNT == RETRY_MAX) begin
                        state_nxt = S_FAULT;
                    end else begin
                        state_nxt = S_HOLD;
                        retry_nxt = RETRY_COUNT + 3'd1;
                    end
                end
            end
            S_STABLE: begin
                // A dropout sends us back to waiting without charging a retry.
                if (!lock_s) begin
                    state_nxt = S_WAIT_LOCK;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = S_RUN;
                    retry_nxt = 3'd0;
                end
            end
            S_RUN: begin
                if (!lock_s) state_nxt = S_HOLD;
            end
            S_FAULT: begin
                state_nxt = S_FAULT;
            end
            default: begin
                state_nxt = S_HOLD;
            end
        endcase
        if (FORCE_RELOCK) begin
            state_nxt = S_HOLD;
            retry_nxt = 3'd0;
        end
    end

    // Loss counting is independent of FORCE_RELOCK so a coincident loss is never dropped.
    always_comb begin
        loss_nxt = LOSS_COUNT;
        if (state == S_RUN && !lock_s && LOSS_COUNT != 8'hFF) begin
            loss_nxt = LOSS_COUNT + 8'd1;
        end
        cnt_clr = FORCE_RELOCK || (state_nxt != state);
    end

    always_comb begin
        resetb_nxt    = !(state_nxt inside {S_HOLD, S_FAULT});
        sys_reset_nxt = (state_nxt != S_RUN);
        ready_nxt     = (state_nxt == S_RUN);
        fault_nxt     = (state_nxt == S_FAULT);
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed and randomized checks of pll_lock_supervisor against a countdown-style reference model.
module tb_pll_lock_supervisor;

    localparam int HOLD = 4;
    localparam int TO   = 20;
    localparam int ST   = 8;
    localparam int MR   = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lock = 1'b0;
    logic       force_r = 1'b0;
    logic       rstb;
    logic       sysr;
    logic       ready;
    logic       fault;
    logic [2:0] retry;
    logic [7:0] loss;

    pll_lock_supervisor #(
        .HOLD_CYCLES  (HOLD),
        .LOCK_TIMEOUT (TO),
        .STABLE_CYCLES(ST),
        .MAX_RETRIES  (MR)
    ) dut (
        .REFERENCECLK(clk),
        .RESET       (rst),
        .LOCK        (lock),
        .FORCE_RELOCK(force_r),
        .PLL_RESETB  (rstb),
        .SYS_RESET   (sysr),
        .READY       (ready),
        .FAULT       (fault),
        .RETRY_COUNT (retry),
        .LOSS_COUNT  (loss)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit saw_low;
    bit saw_ready;

    // Reference model: phase plus cycles remaining, lock delayed through a 2-entry queue.
    typedef enum {PH_RESET_PLL, PH_AWAIT_LOCK, PH_QUALIFY, PH_RUNNING, PH_FAILED} ph_t;
    ph_t m_ph;
    int  m_left;
    int  m_retry;
    int  m_loss;
    bit  m_sync[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ph    = PH_RESET_PLL;
        m_left  = HOLD;
        m_retry = 0;
        m_loss  = 0;
        m_sync.delete();
        m_sync.push_back(1'b0);
        m_sync.push_back(1'b0);
    endtask

    task automatic model_edge(input bit lk, input bit fr);
        bit ls;
        ls = m_sync.pop_front();
        m_sync.push_back(lk);
        if (m_ph == PH_RUNNING && !ls && m_loss < 255) m_loss++;
        if (fr) begin
            m_ph    = PH_RESET_PLL;
            m_left  = HOLD;
            m_retry = 0;
        end else begin
            case (m_ph)
                PH_RESET_PLL: begin
                    m_left--;
                    if (m_left == 0) begin m_ph = PH_AWAIT_LOCK; m_left = TO; end
                end
                PH_AWAIT_LOCK: begin
                    if (ls) begin
                        m_ph = PH_QUALIFY; m_left = ST;
                    end else begin
                        m_left--;
                        if (m_left == 0) begin
                            if (m_retry == MR) m_ph = PH_FAILED;
                            else begin m_retry++; m_ph = PH_RESET_PLL; m_left = HOLD; end
                        end
                    end
                end
                PH_QUALIFY: begin
                    if (!ls) begin
                        m_ph = PH_AWAIT_LOCK; m_left = TO;
                    end else begin
                        m_left--;
                        if (m_left == 0) begin m_ph = PH_RUNNING; m_retry = 0; end
                    end
                end
                PH_RUNNING: begin
                    if (!ls) begin m_ph = PH_RESET_PLL; m_left = HOLD; end
                end
                default: ;
            endcase
        end
    endtask

    function automatic logic [14:0] m_out();
        logic rb;
        rb = !(m_ph == PH_RESET_PLL || m_ph == PH_FAILED);
        return {rb, m_ph != PH_RUNNING, m_ph == PH_RUNNING, m_ph == PH_FAILED,
                3'(m_retry), 8'(m_loss)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (rst) model_reset();
        else     model_edge(lock, force_r);
        chk("model", {rstb, sysr, ready, fault, retry, loss}, m_out());
        if (!rstb) saw_low = 1'b1;
        if (ready) saw_ready = 1'b1;
    endtask

    function automatic logic sel(input int which);
        case (which)
            0:       return rstb;
            1:       return ready;
            default: return fault;
        endcase
    endfunction

    task automatic wait_for(input int which, input logic val, input int bound,
                            input string tag, output int n);
        n = 0;
        while (n < bound && sel(which) !== val) begin
            step();
            n++;
        end
        n_cmp++;
        assert (sel(which) === val) else begin
            n_err++;
            $error("FAIL %s timeout after %0d cycles observed=%b expected=%b", tag, n, sel(which), val);
        end
    endtask

    initial begin
        int n;
        model_reset();
        repeat (3) step();
        #3;
        chk("rst_rstb", rstb, 0);
        chk("rst_sysr", sysr, 1);
        chk("rst_ready", ready, 0);
        chk("rst_fault", fault, 0);
        chk("rst_retry", retry, 0);
        chk("rst_loss", loss, 0);

        // Nominal acquisition
        rst = 1'b0;
        wait_for(0, 1'b1, 50, "nom_hold", n);
        chk("nom_hold_len", n, HOLD);
        repeat (5) step();
        lock = 1'b1;
        // Counted from the first sampling edge, READY arrives STABLE+2 edges later.
        wait_for(1, 1'b1, 100, "nom_ready", n);
        chk("nom_ready_lat", n, ST + 3);
        chk("nom_sysr", sysr, 0);
        chk("nom_retry", retry, 0);

        // Lock loss in RUN
        lock = 1'b0;
        wait_for(1, 1'b0, 20, "loss_ready", n);
        chk("loss_lat", n, 3);
        chk("loss_cnt", loss, 1);
        chk("loss_rstb", rstb, 0);
        wait_for(0, 1'b1, 20, "loss_hold", n);
        chk("loss_hold_len", n, HOLD);
        lock = 1'b1;
        wait_for(1, 1'b1, 100, "reacq", n);
        chk("reacq_lat", n, ST + 3);

        // Glitch during STABLE
        lock = 1'b0;
        wait_for(1, 1'b0, 20, "gl_drop", n);
        wait_for(0, 1'b1, 20, "gl_hold", n);
        saw_low   = 1'b0;
        saw_ready = 1'b0;
        lock = 1'b1;
        repeat (7) step();
        lock = 1'b0;
        repeat (3) step();
        lock = 1'b1;
        chk("glitch_ready", saw_ready, 0);
        wait_for(1, 1'b1, 100, "glitch_reacq", n);
        chk("glitch_lat", n, ST + 3);
        chk("glitch_no_pulse", saw_low, 0);

        // FORCE_RELOCK coincident with a loss in RUN
        lock = 1'b0;
        step();
        step();
        force_r = 1'b1;
        step();
        force_r = 1'b0;
        chk("force_run_loss", loss, 3);
        chk("force_run_rstb", rstb, 0);
        chk("force_run_ready", ready, 0);
        wait_for(0, 1'b1, 20, "force_run_hold", n);
        chk("force_run_hold_len", n, HOLD);

        // Lock never arrives
        for (int a = 0; a <= MR; a++) begin
            wait_for(0, 1'b0, 100, "nolock_wait", n);
            chk("nolock_wait_len", n, TO);
            if (a < MR) begin
                chk("nolock_retry", retry, a + 1);
                wait_for(0, 1'b1, 20, "nolock_hold", n);
                chk("nolock_hold_len", n, HOLD);
            end
        end
        chk("fault_flag", fault, 1);
        chk("fault_retry", retry, MR);
        chk("fault_rstb", rstb, 0);
        chk("fault_sysr", sysr, 1);
        repeat (5) step();
        chk("fault_held", fault, 1);

        // FORCE_RELOCK from FAULT
        force_r = 1'b1;
        step();
        force_r = 1'b0;
        chk("ffault_fault", fault, 0);
        chk("ffault_retry", retry, 0);
        chk("ffault_rstb", rstb, 0);
        wait_for(0, 1'b1, 20, "ffault_hold", n);
        chk("ffault_hold_len", n, HOLD);

        // Random lock behaviour with occasional relock requests
        for (int i = 0; i < 40; i++) begin
            lock    = 1'($urandom_range(0, 1));
            force_r = ($urandom_range(0, 15) == 0);
            step();
            force_r = 1'b0;
            repeat ($urandom_range(0, 25)) step();
        end

        force_r = 1'b1;
        step();
        force_r = 1'b0;
        lock = 1'b1;
        wait_for(1, 1'b1, 100, "rand_reacq", n);

        // LOSS_COUNT saturation
        for (int i = 0; i < 256; i++) begin
            lock = 1'b0;
            wait_for(1, 1'b0, 20, "sat_drop", n);
            repeat ($urandom_range(0, 3)) step();
            lock = 1'b1;
            wait_for(1, 1'b1, 100, "sat_reacq", n);
        end
        chk("loss_sat", loss, 255);

        // Asynchronous reset between edges while in RUN
        #3;
        rst = 1'b1;
        #1;
        chk("arst_rstb", rstb, 0);
        chk("arst_sysr", sysr, 1);
        chk("arst_ready", ready, 0);
        chk("arst_loss", loss, 0);
        model_reset();
        step();
        step();
        rst = 1'b0;
        wait_for(0, 1'b1, 20, "post_rst", n);
        chk("post_rst_hold_len", n, HOLD);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
